// File: rtl/div_scheduler.sv
// rtl/div_scheduler.sv - round-robin front end sharing one iterative 16-bit divider
module div_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [16*NUM_REQ-1:0]   req_x,
  input  logic [16*NUM_REQ-1:0]   req_y,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [15:0]             resp_q,
  output logic [15:0]             resp_r,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    div_start,
  output logic [15:0]             div_x,
  output logic [15:0]             div_y,
  input  logic                    div_done,
  input  logic [15:0]             div_q,
  input  logic [15:0]             div_r
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // last WAIT count value before the op is abandoned
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ERRZ,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] g_q, g_d;
  logic [15:0]   x_q, x_d;
  logic [15:0]   y_q, y_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   quo_q, quo_d;
  logic [15:0]   rem_q, rem_d;
  logic          err_q, err_d;

  logic [15:0]   xs [NUM_REQ];
  logic [15:0]   ys [NUM_REQ];
  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          grant;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
    assign xs[i] = req_x[16*i +: 16];
    assign ys[i] = req_y[16*i +: 16];
  end

  // first valid requester at or after the round-robin pointer, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign grant     = (state_q == S_IDLE) && found && !reset;
  assign busy      = (state_q != S_IDLE);
  assign div_start = (state_q == S_ISSUE);
  assign div_x     = x_q;
  assign div_y     = y_q;
  assign resp_q    = quo_q;
  assign resp_r    = rem_q;
  assign resp_err  = err_q;

  // one-hot accept and response pulses
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (grant) begin
      req_ready[pick] = 1'b1;
    end
    if (state_q == S_RESP) begin
      resp_valid[g_q] = 1'b1;
    end
  end

  // operation sequencing: grant, start, wait for done or timeout, respond
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          g_d     = pick;
          x_d     = xs[pick];
          y_d     = ys[pick];
          state_d = (ys[pick] == 16'd0) ? S_ERRZ : S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // a result arriving on the timeout cycle is still delivered
        if (div_done) begin
          quo_d   = div_q;
          rem_d   = div_r;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          quo_d   = 16'd0;
          rem_d   = 16'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ERRZ: begin
        quo_d   = 16'hFFFF;
        rem_d   = x_q;
        err_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        rr_d    = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_div_scheduler.sv
// tb/tb_div_scheduler.sv - scoreboard bench for div_scheduler
module tb_div_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_x;
  logic [63:0] req_y;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [15:0] resp_q;
  logic [15:0] resp_r;
  logic        resp_err;
  logic        busy;
  logic        div_start;
  logic [15:0] div_x;
  logic [15:0] div_y;
  logic        div_done;
  logic [15:0] div_q;
  logic [15:0] div_r;

  div_scheduler #(.NUM_REQ(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_q(resp_q), .resp_r(resp_r), .resp_err(resp_err),
    .busy(busy), .div_start(div_start), .div_x(div_x), .div_y(div_y),
    .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  typedef struct {
    int          idx;
    logic [15:0] q;
    logic [15:0] r;
    logic        err;
    int          lat;
    bit          st;
  } rsp_t;

  rsp_t        rsp_exp[$];
  int          gnt_exp[$];
  string       chk_name[$];
  logic [31:0] chk_act[$];
  logic [31:0] chk_exp[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int start_cnt = 0;
  int acc_cyc = 0;
  int start_cyc = 0;

  int          md_delay = 3;
  bit          md_mute = 0;
  bit          md_poke = 0;
  int          busy_cnt;
  logic [15:0] lx, ly;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // model of the shared divide unit; acts 2 time units after each edge
  initial begin
    div_done = 0; div_q = 0; div_r = 0; busy_cnt = 0; lx = 0; ly = 1;
    forever begin
      @(posedge clk); #2;
      div_done = 0;
      if (md_poke) begin
        div_done = 1; div_q = 16'h5555; div_r = 16'h5555;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          div_done = 1; div_q = lx / ly; div_r = lx % ly;
        end
      end
      if (div_start) begin
        lx = div_x; ly = div_y;
        busy_cnt = md_mute ? 0 : md_delay;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
    end
  endtask

  // monitor: all comparisons happen here, on the falling edge
  initial begin
    rsp_t        p;
    int          e;
    logic [31:0] one;
    one = 32'd1;
    forever begin
      @(negedge clk);
      if (div_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (|req_ready) begin
        acc_cyc = cyc;
        if (gnt_exp.size() == 0) cmp("grant_unexpected", 32'(req_ready), 32'd0);
        else begin
          e = gnt_exp.pop_front();
          cmp("grant", 32'(req_ready), one << e);
        end
      end
      if (|resp_valid) begin
        rsp_cnt++;
        if (rsp_exp.size() == 0) cmp("resp_unexpected", 32'(resp_valid), 32'd0);
        else begin
          p = rsp_exp.pop_front();
          cmp("resp_valid", 32'(resp_valid), one << p.idx);
          cmp("resp_q", 32'(resp_q), 32'(p.q));
          cmp("resp_r", 32'(resp_r), 32'(p.r));
          cmp("resp_err", 32'(resp_err), 32'(p.err));
          if (p.lat >= 0) cmp("resp_latency", 32'(cyc - acc_cyc), 32'(p.lat));
          if (p.st) cmp("start_latency", 32'(start_cyc - acc_cyc), 32'd1);
        end
      end
      while (chk_act.size() > 0) begin
        cmp(chk_name.pop_front(), chk_act.pop_front(), chk_exp.pop_front());
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    chk_name.push_back(nm);
    chk_act.push_back(a);
    chk_exp.push_back(e);
  endtask

  task automatic push_rsp(input int idx, input logic [15:0] q, input logic [15:0] r,
                          input logic err, input int lat, input bit st);
    rsp_t p;
    p.idx = idx; p.q = q; p.r = r; p.err = err; p.lat = lat; p.st = st;
    rsp_exp.push_back(p);
  endtask

  task automatic set_op(input int i, input logic [15:0] x, input logic [15:0] y);
    req_x[16*i +: 16] = x;
    req_y[16*i +: 16] = y;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
    check({pfx, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({pfx, "_resp_q"}, 32'(resp_q), 32'd0);
    check({pfx, "_resp_r"}, 32'(resp_r), 32'd0);
    check({pfx, "_resp_err"}, 32'(resp_err), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_div_start"}, 32'(div_start), 32'd0);
    check({pfx, "_div_x"}, 32'(div_x), 32'd0);
    check({pfx, "_div_y"}, 32'(div_y), 32'd0);
  endtask

  // run until rsp_cnt reaches target; drop=1 releases each requester on its accept
  task automatic run(input int target, input bit drop, input int budget);
    logic [3:0] rdy;
    bit         fin;
    int         c;
    fin = 0; c = 0;
    while (!fin && c < budget) begin
      @(negedge clk); #1;
      if (rsp_cnt >= target) begin
        if (!drop) req_valid = '0;
        fin = 1;
      end else begin
        rdy = req_ready;
        @(posedge clk); #1;
        if (drop) req_valid = req_valid & ~rdy;
        c++;
      end
    end
    if (!fin) begin
      req_valid = '0;
      check("run_timeout", 32'(rsp_cnt), 32'(target));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int tgt;
    int s0;
    reset = 1; req_valid = 4'hF; req_x = '0; req_y = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    req_valid = '0;
    @(posedge clk); #1;
    reset = 0;

    // single request: 100 / 7 = 14 r 2, done 14 cycles after start
    md_delay = 14;
    set_op(0, 16'd100, 16'd7);
    gnt_exp.push_back(0);
    push_rsp(0, 16'd14, 16'd2, 1'b0, 16, 1'b1);
    tgt = rsp_cnt + 1; req_valid = 4'b0001;
    run(tgt, 1, 60);
    repeat (3) @(posedge clk);
    #1;
    check("hold_q", 32'(resp_q), 32'd14);
    check("hold_r", 32'(resp_r), 32'd2);

    // divide by zero from requester 2
    s0 = start_cnt;
    set_op(2, 16'h1234, 16'd0);
    gnt_exp.push_back(2);
    push_rsp(2, 16'hFFFF, 16'h1234, 1'b1, 2, 1'b0);
    tgt = rsp_cnt + 1; req_valid = 4'b0100;
    run(tgt, 1, 20);
    check("div0_no_start", 32'(start_cnt), 32'(s0));

    // timeout: unit never answers
    md_mute = 1;
    set_op(1, 16'd50, 16'd3);
    gnt_exp.push_back(1);
    push_rsp(1, 16'd0, 16'd0, 1'b1, 17, 1'b1);
    tgt = rsp_cnt + 1; req_valid = 4'b0010;
    run(tgt, 1, 60);
    md_mute = 0;

    // next request after a timeout: 20 / 6 = 3 r 2
    md_delay = 2;
    set_op(3, 16'd20, 16'd6);
    gnt_exp.push_back(3);
    push_rsp(3, 16'd3, 16'd2, 1'b0, 4, 1'b1);
    tgt = rsp_cnt + 1; req_valid = 4'b1000;
    run(tgt, 1, 30);

    // stray done while idle
    s0 = rsp_cnt;
    md_poke = 1;
    @(posedge clk); #1;
    md_poke = 0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_done_no_resp", 32'(rsp_cnt), 32'(s0));
    check("idle_done_busy", 32'(busy), 32'd0);
    check("idle_done_hold_q", 32'(resp_q), 32'd3);

    // done on the same cycle the timeout fires: 200 / 9 = 22 r 2
    md_delay = 15;
    set_op(0, 16'd200, 16'd9);
    gnt_exp.push_back(0);
    push_rsp(0, 16'd22, 16'd2, 1'b0, 17, 1'b1);
    tgt = rsp_cnt + 1; req_valid = 4'b0001;
    run(tgt, 1, 60);

    // reset during WAIT
    md_delay = 10;
    set_op(1, 16'd30, 16'd4);
    gnt_exp.push_back(1);
    req_valid = 4'b0010;
    @(negedge clk); #1;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_before_reset", 32'(busy), 32'd1);
    reset = 1;
    @(posedge clk); #1;
    check_zero("midop");
    reset = 0;
    s0 = rsp_cnt;
    repeat (15) @(posedge clk);
    #1;
    check("late_done_no_resp", 32'(rsp_cnt), 32'(s0));

    // pointer restarted at 0: requester 0 wins over 1
    md_delay = 1;
    set_op(0, 16'd7, 16'd7);
    set_op(1, 16'd8, 16'd3);
    gnt_exp.push_back(0);
    gnt_exp.push_back(1);
    push_rsp(0, 16'd1, 16'd0, 1'b0, 3, 1'b1);
    push_rsp(1, 16'd2, 16'd2, 1'b0, 3, 1'b1);
    tgt = rsp_cnt + 2; req_valid = 4'b0011;
    run(tgt, 1, 40);

    // round robin with all requesters held valid from reset release
    md_delay = 3;
    set_op(0, 16'd1000, 16'd10);
    set_op(1, 16'd77, 16'd5);
    set_op(2, 16'd65535, 16'd256);
    set_op(3, 16'd9, 16'd10);
    reset = 1; req_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    gnt_exp.push_back(0); gnt_exp.push_back(1); gnt_exp.push_back(2);
    gnt_exp.push_back(3); gnt_exp.push_back(0);
    push_rsp(0, 16'd100, 16'd0, 1'b0, 5, 1'b1);
    push_rsp(1, 16'd15, 16'd2, 1'b0, 5, 1'b1);
    push_rsp(2, 16'd255, 16'd255, 1'b0, 5, 1'b1);
    push_rsp(3, 16'd0, 16'd9, 1'b0, 5, 1'b1);
    push_rsp(0, 16'd100, 16'd0, 1'b0, 5, 1'b1);
    tgt = rsp_cnt + 5;
    reset = 0;
    run(tgt, 0, 200);

    repeat (4) @(posedge clk);
    #1;
    check("sb_rsp_left", 32'(rsp_exp.size()), 32'd0);
    check("sb_gnt_left", 32'(gnt_exp.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
